pwm_duty_generator: RTL



---
 rtl/pwm_duty_generator.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pwm_duty_generator.sv
// PWM stage around the external 4-bit ripple subtractor.
// Shadow duty is applied at period boundaries; the borrow feeds pwm_out.
module pwm_duty_generator #(
  parameter int CLK_DIV = 500,
  parameter int DIV_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] duty_in,
  input  logic       duty_load,
  input  logic       duty_inc,
  input  logic       duty_dec,
  output logic [3:0] cmp_a,
  output logic [3:0] cmp_b,
  output logic       cmp_cin,
  input  logic       cmp_borrow,
  output logic       pwm_out,
  output logic       period_start,
  output logic [3:0] duty_q
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_e           state;
  state_e           state_nxt;
  logic [DIV_W-1:0] presc;
  logic [3:0]       cnt;
  logic [3:0]       duty_act;
  logic [3:0]       duty_nxt;
  logic             run;
  logic             start;
  logic             tick;
  logic             wrap;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: en alone decides between IDLE and RUN
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en)  state_nxt = RUN;
      RUN:     if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM decode: run entry, prescaler tick and period wrap
  always_comb begin
    run   = (state == RUN) && en;
    start = (state == IDLE) && en;
    tick  = (presc == DIV_LAST);
    wrap  = run && tick && (cnt == 4'hf);
  end

  // Shadow duty update: load wins, inc/dec cancel, both saturate
  always_comb begin
    duty_nxt = duty_q;
    priority case (1'b1)
      duty_load:
        duty_nxt = duty_in;
      duty_inc && !duty_dec:
        if (duty_q != 4'hf) duty_nxt = duty_q + 4'd1;
      duty_dec && !duty_inc:
        if (duty_q != 4'h0) duty_nxt = duty_q - 4'd1;
      default:
        duty_nxt = duty_q;
    endcase
  end

  // Shadow duty register, updated in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) duty_q <= 4'h0;
    else        duty_q <= duty_nxt;
  end

  // Active duty only changes on run entry or period wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     duty_act <= 4'h0;
    else if (start) duty_act <= duty_q;
    else if (wrap)  duty_act <= duty_nxt;
  end

  // Prescaler and step counter, cleared whenever not running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      cnt   <= 4'h0;
    end else if (!run) begin
      presc <= '0;
      cnt   <= 4'h0;
    end else if (tick) begin
      presc <= '0;
      cnt   <= cnt + 4'd1;
    end else begin
      presc <= presc + DIV_W'(1);
    end
  end

  // Registered PWM pin and period marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= run ? cmp_borrow : 1'b0;
      period_start <= start || wrap;
    end
  end

  assign cmp_a   = cnt;
  assign cmp_b   = duty_act;
  assign cmp_cin = 1'b0;

endmodule
